// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory.
// One outstanding transaction; misaligned accesses and memory timeouts become exception responses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_valid,
    input  logic [31:0] fetch_req_addr,
    output logic        fetch_req_ready,
    output logic        fetch_resp_valid,
    output logic [31:0] fetch_resp_data,
    output logic        fetch_resp_exc_valid,
    output logic [3:0]  fetch_resp_exc_code,
    input  logic        data_req_valid,
    input  logic        data_req_write,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_wdata,
    output logic        data_req_ready,
    output logic        data_resp_valid,
    output logic [31:0] data_resp_rdata,
    output logic        data_resp_exc_valid,
    output logic [3:0]  data_resp_exc_code,
    output logic        mem_req_valid,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_exc_valid,
    input  logic [3:0]  mem_resp_exc_code
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;   // 1 = data granted last
    logic                req_data_q, req_data_d;       // 1 = current owner is data port
    logic                req_write_q, req_write_d;
    logic [DATA_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0]   f_data_q, f_data_d, d_data_q, d_data_d;
    logic                f_exc_q, f_exc_d, d_exc_q, d_exc_d;
    logic [CODE_W-1:0]   f_code_q, f_code_d, d_code_q, d_code_d;

    logic                grant_fetch, grant_data;
    logic [DATA_W-1:0]   sel_addr;
    logic                sel_write;
    logic [CNT_W-1:0]    cnt_inc;
    logic                resp_load, resp_is_data, resp_exc;
    logic [DATA_W-1:0]   resp_data;
    logic [CODE_W-1:0]   resp_code;

    // Next-state, request latching and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        req_data_d   = req_data_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        f_data_d     = f_data_q;
        f_exc_d      = f_exc_q;
        f_code_d     = f_code_q;
        d_data_d     = d_data_q;
        d_exc_d      = d_exc_q;
        d_code_d     = d_code_q;
        resp_load    = 1'b0;
        resp_is_data = req_data_q;
        resp_exc     = 1'b0;
        resp_data    = '0;
        resp_code    = '0;
        cnt_inc      = cnt_q + CNT_W'(1);
        grant_fetch  = fetch_req_valid && (!data_req_valid || last_grant_q);
        grant_data   = data_req_valid && !grant_fetch;
        sel_addr     = grant_fetch ? fetch_req_addr : data_req_addr;
        sel_write    = grant_data && data_req_write;

        case (state_q)
            S_IDLE: begin
                if (grant_fetch || grant_data) begin
                    req_data_d   = grant_data;
                    last_grant_d = grant_data;
                    req_write_d  = sel_write;
                    req_addr_d   = sel_addr;
                    req_wdata_d  = grant_data ? data_req_wdata : '0;
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d      = S_RESP;
                        resp_load    = 1'b1;
                        resp_is_data = grant_data;
                        resp_exc     = 1'b1;
                        resp_code    = !grant_data ? CODE_W'(0) : (sel_write ? CODE_W'(6) : CODE_W'(4));
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response in the timeout cycle still wins.
                if (mem_resp_valid) begin
                    state_d   = S_RESP;
                    cnt_d     = '0;
                    resp_load = 1'b1;
                    resp_data = req_write_q ? '0 : mem_resp_data;
                    resp_exc  = mem_resp_exc_valid;
                    resp_code = mem_resp_exc_code;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d   = S_RESP;
                    cnt_d     = '0;
                    resp_load = 1'b1;
                    resp_exc  = 1'b1;
                    resp_code = !req_data_q ? CODE_W'(1) : (req_write_q ? CODE_W'(7) : CODE_W'(5));
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_load) begin
            if (resp_is_data) begin
                d_data_d = resp_data;
                d_exc_d  = resp_exc;
                d_code_d = resp_code;
            end else begin
                f_data_d = resp_data;
                f_exc_d  = resp_exc;
                f_code_d = resp_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            req_data_q   <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            f_data_q     <= '0;
            f_exc_q      <= 1'b0;
            f_code_q     <= '0;
            d_data_q     <= '0;
            d_exc_q      <= 1'b0;
            d_code_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            req_data_q   <= req_data_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            f_data_q     <= f_data_d;
            f_exc_q      <= f_exc_d;
            f_code_q     <= f_code_d;
            d_data_q     <= d_data_d;
            d_exc_q      <= d_exc_d;
            d_code_q     <= d_code_d;
        end
    end

    // Everything is forced low while reset is held.
    assign fetch_req_ready      = !reset && (state_q == S_IDLE) && grant_fetch;
    assign data_req_ready       = !reset && (state_q == S_IDLE) && grant_data;
    assign fetch_resp_valid     = !reset && (state_q == S_RESP) && !req_data_q;
    assign data_resp_valid      = !reset && (state_q == S_RESP) && req_data_q;
    assign fetch_resp_data      = reset ? '0 : f_data_q;
    assign fetch_resp_exc_valid = !reset && f_exc_q;
    assign fetch_resp_exc_code  = reset ? '0 : f_code_q;
    assign data_resp_rdata      = reset ? '0 : d_data_q;
    assign data_resp_exc_valid  = !reset && d_exc_q;
    assign data_resp_exc_code   = reset ? '0 : d_code_q;
    assign mem_req_valid        = !reset && (state_q == S_ISSUE);
    assign mem_req_write        = mem_req_valid && req_write_q;
    assign mem_req_addr         = mem_req_valid ? req_addr_q : '0;
    assign mem_req_wdata        = mem_req_valid ? req_wdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the bench plays the memory and predicts every
// transaction from the arbitration / latency / exception rules.
module tb_mem_port_arbiter;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_valid, fetch_req_ready, fetch_resp_valid, fetch_resp_exc_valid;
    logic [31:0] fetch_req_addr, fetch_resp_data;
    logic [3:0]  fetch_resp_exc_code;
    logic        data_req_valid, data_req_write, data_req_ready, data_resp_valid, data_resp_exc_valid;
    logic [31:0] data_req_addr, data_req_wdata, data_resp_rdata;
    logic [3:0]  data_resp_exc_code;
    logic        mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid, mem_resp_exc_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_resp_exc_code;

    int checks = 0;
    int errors = 0;

    // Reference model state: who won last, and what each response port should hold.
    logic        m_last_data;
    logic [31:0] m_f_data, m_d_data;
    logic        m_f_exc, m_d_exc;
    logic [3:0]  m_f_code, m_d_code;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready), .fetch_resp_valid(fetch_resp_valid),
        .fetch_resp_data(fetch_resp_data), .fetch_resp_exc_valid(fetch_resp_exc_valid),
        .fetch_resp_exc_code(fetch_resp_exc_code),
        .data_req_valid(data_req_valid), .data_req_write(data_req_write),
        .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
        .data_req_ready(data_req_ready), .data_resp_valid(data_resp_valid),
        .data_resp_rdata(data_resp_rdata), .data_resp_exc_valid(data_resp_exc_valid),
        .data_resp_exc_code(data_resp_exc_code),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .mem_resp_exc_valid(mem_resp_exc_valid),
        .mem_resp_exc_code(mem_resp_exc_code)
    );

    task automatic clear_inputs();
        fetch_req_valid = 1'b0; fetch_req_addr = '0;
        data_req_valid = 1'b0; data_req_write = 1'b0; data_req_addr = '0; data_req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        mem_resp_exc_valid = 1'b0; mem_resp_exc_code = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_last_data = 1'b1;
        m_f_data = '0; m_f_exc = 1'b0; m_f_code = '0;
        m_d_data = '0; m_d_exc = 1'b0; m_d_code = '0;
    endtask

    // Presents one request, acts as the memory, and reports what it observed.
    task automatic run_txn(
        input logic fv, input logic [31:0] fa,
        input logic dv, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
        input int rdly, input int rcyc,
        input logic [31:0] rdata, input logic rexc, input logic [3:0] rcode,
        output logic o_fready, output logic o_dready, output int o_lat,
        output logic o_is_data, output logic [31:0] o_rdata, output logic o_exc,
        output logic [3:0] o_code, output int o_nstrobe, output int o_nhs,
        output logic [31:0] o_addr, output logic [31:0] o_wdata, output logic o_write,
        output logic o_stable, output logic o_zero_ok);
        int issue_seen = 0;
        int wait_k = 0;
        int bound;
        logic waiting = 1'b0;
        o_lat = -1; o_is_data = 1'b0; o_rdata = '0; o_exc = 1'b0; o_code = '0;
        o_nstrobe = 0; o_nhs = 0; o_addr = '0; o_wdata = '0; o_write = 1'b0;
        o_stable = 1'b1; o_zero_ok = 1'b1;
        bound = rdly + ((rcyc + 1 > int'(TO)) ? rcyc + 1 : int'(TO)) + 6;
        @(negedge clk);
        fetch_req_valid = fv; fetch_req_addr = fa;
        data_req_valid = dv; data_req_write = dw; data_req_addr = da; data_req_wdata = dwd;
        #1;
        o_fready = fetch_req_ready;
        o_dready = data_req_ready;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (n == 1) begin
                fetch_req_valid = 1'b0; data_req_valid = 1'b0;
                fetch_req_addr = $urandom; data_req_addr = $urandom;
                data_req_wdata = $urandom; data_req_write = 1'($urandom);
            end
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = $urandom;
            mem_resp_exc_valid = 1'b0; mem_resp_exc_code = '0;
            if (waiting) begin
                if (wait_k == rcyc) begin
                    mem_resp_valid = 1'b1; mem_resp_data = rdata;
                    mem_resp_exc_valid = rexc; mem_resp_exc_code = rcode;
                end
                wait_k++;
            end else if (mem_req_valid) begin
                if (issue_seen == 0) begin
                    o_addr = mem_req_addr; o_wdata = mem_req_wdata; o_write = mem_req_write;
                end else if (mem_req_addr !== o_addr || mem_req_wdata !== o_wdata || mem_req_write !== o_write) begin
                    o_stable = 1'b0;
                end
                mem_req_ready = (issue_seen >= rdly);
                if (mem_req_ready) begin
                    o_nhs++;
                    waiting = 1'b1;
                end
                issue_seen++;
            end else if (mem_req_addr !== '0 || mem_req_wdata !== '0 || mem_req_write !== 1'b0) begin
                o_zero_ok = 1'b0;
            end
            #1;
            if (fetch_resp_valid || data_resp_valid) begin
                o_nstrobe += int'(fetch_resp_valid) + int'(data_resp_valid);
                if (o_lat < 0) begin
                    o_lat = n;
                    o_is_data = data_resp_valid;
                    o_rdata = data_resp_valid ? data_resp_rdata : fetch_resp_data;
                    o_exc = data_resp_valid ? data_resp_exc_valid : fetch_resp_exc_valid;
                    o_code = data_resp_valid ? data_resp_exc_code : fetch_resp_exc_code;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        fetch_req_valid = 1'b1; data_req_valid = 1'b1;
        #1;
        checks++;
        if ({fetch_req_ready, data_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready_during got %b want 00", {fetch_req_ready, data_req_ready});
        end
        @(negedge clk); #1;
        checks++;
        if ({fetch_req_ready, data_req_ready, fetch_resp_valid, data_resp_valid, mem_req_valid, mem_req_write} !== 6'b0
            || mem_req_addr !== '0 || mem_req_wdata !== '0) begin
            errors++; $display("FAIL reset_ctrl_outputs got %b addr %h want 0", {fetch_req_ready, data_req_ready,
                fetch_resp_valid, data_resp_valid, mem_req_valid, mem_req_write}, mem_req_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        fetch_req_valid = 1'b0; data_req_valid = 1'b0;
        #1;
        checks++;
        if (fetch_resp_data !== '0 || data_resp_rdata !== '0 || fetch_resp_exc_valid !== 1'b0 || data_resp_exc_valid !== 1'b0
            || fetch_resp_exc_code !== '0 || data_resp_exc_code !== '0) begin
            errors++; $display("FAIL reset_resp_regs got %h %h %b %b want 0", fetch_resp_data, data_resp_rdata,
                fetch_resp_exc_valid, data_resp_exc_valid);
        end
        m_last_data = 1'b1;
        m_f_data = '0; m_f_exc = 1'b0; m_f_code = '0;
        m_d_data = '0; m_d_exc = 1'b0; m_d_code = '0;
    endtask

    task automatic test_single_fetch();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        run_txn(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0, '0, 0, 0, 32'h0000_0013, 1'b0, 4'd0,
                fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
        checks++; if ({fr, dr} !== 2'b10) begin errors++; $display("FAIL fetch_ready got %b want 10", {fr, dr}); end
        checks++; if (ad !== 32'h0000_1000) begin errors++; $display("FAIL fetch_mem_addr got %h want 00001000", ad); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL fetch_latency got %0d want 3", lat); end
        checks++; if ({isd, ex} !== 2'b00 || rd !== 32'h13) begin
            errors++; $display("FAIL fetch_resp got is_data=%b exc=%b data=%h want 0 0 00000013", isd, ex, rd); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL fetch_strobe_count got %0d want 1", ns); end
        m_last_data = 1'b0; m_f_data = 32'h13; m_f_exc = 1'b0; m_f_code = 4'd0;
    endtask

    task automatic test_arbitration();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        logic want_data;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            want_data = (k % 2) == 1;
            run_txn(1'b1, 32'h100 + 32'(k * 16), 1'b1, 1'b0, 32'h200 + 32'(k * 16), '0, 0, 0,
                    32'hA000 + 32'(k), 1'b0, 4'd0, fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
            checks++;
            if ({fr, dr} !== {!want_data, want_data} || isd !== want_data) begin
                errors++; $display("FAIL arb_conflict_%0d got ready=%b resp_data_port=%b want data_port=%b", k, {fr, dr}, isd, want_data);
            end
            checks++;
            if (ad !== (want_data ? 32'h200 : 32'h100) + 32'(k * 16) || rd !== 32'hA000 + 32'(k)) begin
                errors++; $display("FAIL arb_payload_%0d got addr=%h data=%h", k, ad, rd);
            end
            m_last_data = want_data;
            if (want_data) begin m_d_data = rd; m_d_exc = 1'b0; m_d_code = '0; end
            else begin m_f_data = rd; m_f_exc = 1'b0; m_f_code = '0; end
        end
    endtask

    task automatic test_misaligned();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        logic [31:0] addrs [3] = '{32'h0000_2002, 32'h0000_1001, 32'h0000_3003};
        logic        isdat [3] = '{1'b1, 1'b0, 1'b1};
        logic        iswr  [3] = '{1'b1, 1'b0, 1'b0};
        logic [3:0]  codes [3] = '{4'd6, 4'd0, 4'd4};
        for (int k = 0; k < 3; k++) begin
            run_txn(!isdat[k], addrs[k], isdat[k], iswr[k], addrs[k], 32'h1234_5678, 0, 0, 32'hFFFF_FFFF,
                    1'b0, 4'd0, fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
            checks++;
            if (nh !== 0 || lat !== 1) begin
                errors++; $display("FAIL misalign_%0d_timing got handshakes=%0d latency=%0d want 0 1", k, nh, lat);
            end
            checks++;
            if (isd !== isdat[k] || ex !== 1'b1 || cd !== codes[k] || rd !== '0 || ns !== 1) begin
                errors++; $display("FAIL misalign_%0d_resp got port=%b exc=%b code=%0d data=%h strobes=%0d want %b 1 %0d 0 1",
                    k, isd, ex, cd, rd, ns, isdat[k], codes[k]);
            end
            m_last_data = isdat[k];
            if (isdat[k]) begin m_d_data = '0; m_d_exc = 1'b1; m_d_code = codes[k]; end
            else begin m_f_data = '0; m_f_exc = 1'b1; m_f_code = codes[k]; end
        end
    endtask

    task automatic test_timeout();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        run_txn(1'b0, '0, 1'b1, 1'b0, 32'h0000_4000, '0, 0, 20, 32'hDEAD_BEEF, 1'b0, 4'd0,
                fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
        checks++; if (lat !== 2 + int'(TO)) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, 2 + int'(TO)); end
        checks++; if ({isd, ex} !== 2'b11 || cd !== 4'd5 || rd !== '0) begin
            errors++; $display("FAIL timeout_resp got port=%b exc=%b code=%0d data=%h want 1 1 5 0", isd, ex, cd, rd); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL timeout_late_resp got strobes=%0d want 1", ns); end
        m_last_data = 1'b1; m_d_data = '0; m_d_exc = 1'b1; m_d_code = 4'd5;
        run_txn(1'b0, '0, 1'b1, 1'b0, 32'h0000_4400, '0, 0, int'(TO) - 1, 32'h0BAD_F00D, 1'b0, 4'd0,
                fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
        checks++; if (lat !== 2 + int'(TO) || ex !== 1'b0 || rd !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL timeout_tie got latency=%0d exc=%b data=%h want %0d 0 0badf00d", lat, ex, rd, 2 + int'(TO)); end
        m_d_data = 32'h0BAD_F00D; m_d_exc = 1'b0; m_d_code = '0;
    endtask

    task automatic test_stall();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        run_txn(1'b0, '0, 1'b1, 1'b1, 32'h0000_5000, 32'hCAFE_F00D, 5, 0, 32'hFFFF_0000, 1'b0, 4'd0,
                fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
        checks++; if (st !== 1'b1 || ad !== 32'h0000_5000 || wd !== 32'hCAFE_F00D || wr !== 1'b1) begin
            errors++; $display("FAIL stall_hold got stable=%b addr=%h wdata=%h write=%b", st, ad, wd, wr); end
        checks++; if (lat !== 8 || nh !== 1) begin errors++; $display("FAIL stall_latency got %0d hs=%0d want 8 1", lat, nh); end
        checks++; if (rd !== '0 || ex !== 1'b0 || isd !== 1'b1 || zk !== 1'b1) begin
            errors++; $display("FAIL stall_store_resp got data=%h exc=%b port=%b idle_zero=%b", rd, ex, isd, zk); end
        m_last_data = 1'b1; m_d_data = '0; m_d_exc = 1'b0; m_d_code = '0;
    endtask

    task automatic test_random();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        logic fv, dv, dw, rexc, e_data_port, e_mis, e_exc, e_write; logic [31:0] fa, da, dwd, rdata, e_rd, e_addr;
        logic [3:0] rcode, e_code; int rdly, rcyc, sel, e_lat;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 2);
            fv = (sel != 1); dv = (sel != 0);
            fa = {$urandom_range(0, 65535), 16'h0} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            da = {$urandom_range(0, 65535), 16'h0} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            fa[15:2] = 14'($urandom); da[15:2] = 14'($urandom);
            dw = 1'($urandom); dwd = $urandom; rdata = $urandom;
            rdly = $urandom_range(0, 3); rcyc = $urandom_range(0, 19);
            rexc = ($urandom_range(0, 3) == 0); rcode = rexc ? 4'($urandom) : 4'd0;
            e_data_port = (fv && dv) ? !m_last_data : dv;
            e_addr  = e_data_port ? da : fa;
            e_write = e_data_port && dw;
            e_mis   = (e_addr % 4) != 0;
            if (e_mis) begin
                e_lat = 1; e_exc = 1'b1; e_rd = '0;
                e_code = !e_data_port ? 4'd0 : (e_write ? 4'd6 : 4'd4);
            end else if (rcyc < int'(TO)) begin
                e_lat = 2 + rdly + rcyc + 1; e_exc = rexc; e_code = rcode; e_rd = e_write ? '0 : rdata;
            end else begin
                e_lat = 2 + rdly + int'(TO); e_exc = 1'b1; e_rd = '0;
                e_code = !e_data_port ? 4'd1 : (e_write ? 4'd7 : 4'd5);
            end
            run_txn(fv, fa, dv, dw, da, dwd, rdly, rcyc, rdata, rexc, rcode,
                    fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
            checks++;
            if ({fr, dr} !== {!e_data_port, e_data_port} || isd !== e_data_port || ns !== 1) begin
                errors++; $display("FAIL rand%0d_grant got ready=%b port=%b strobes=%0d want port=%b", i, {fr, dr}, isd, ns, e_data_port);
            end
            checks++;
            if (lat !== e_lat || nh !== (e_mis ? 0 : 1)) begin
                errors++; $display("FAIL rand%0d_latency got %0d hs=%0d want %0d", i, lat, nh, e_lat);
            end
            checks++;
            if (rd !== e_rd || ex !== e_exc || cd !== e_code) begin
                errors++; $display("FAIL rand%0d_resp got %h/%b/%0d want %h/%b/%0d", i, rd, ex, cd, e_rd, e_exc, e_code);
            end
            checks++;
            if (!e_mis && (ad !== e_addr || wr !== e_write || st !== 1'b1 || (e_data_port && wd !== dwd))) begin
                errors++; $display("FAIL rand%0d_memreq got addr=%h write=%b stable=%b want %h %b", i, ad, wr, st, e_addr, e_write);
            end
            m_last_data = e_data_port;
            if (e_data_port) begin m_d_data = e_rd; m_d_exc = e_exc; m_d_code = e_code; end
            else begin m_f_data = e_rd; m_f_exc = e_exc; m_f_code = e_code; end
            #1;
            checks++;
            if (fetch_resp_data !== m_f_data || fetch_resp_exc_valid !== m_f_exc || fetch_resp_exc_code !== m_f_code
                || data_resp_rdata !== m_d_data || data_resp_exc_valid !== m_d_exc || data_resp_exc_code !== m_d_code
                || zk !== 1'b1) begin
                errors++; $display("FAIL rand%0d_hold got f=%h d=%h idle_zero=%b want f=%h d=%h", i,
                    fetch_resp_data, data_resp_rdata, zk, m_f_data, m_d_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic fr, dr, isd, ex, wr, st, zk; int lat, ns, nh; logic [31:0] rd, ad, wd; logic [3:0] cd;
        int strobes = 0;
        @(negedge clk);
        data_req_valid = 1'b1; data_req_write = 1'b0; data_req_addr = 32'h0000_6000;
        @(negedge clk);
        data_req_valid = 1'b0; mem_req_ready = 1'b1;
        repeat (3) begin @(negedge clk); mem_req_ready = 1'b0; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
            #1;
            strobes += int'(fetch_resp_valid) + int'(data_resp_valid);
            if (k == 0) begin
                checks++;
                if ({fetch_req_ready, data_req_ready, mem_req_valid, mem_req_write} !== 4'b0 || mem_req_addr !== '0
                    || fetch_resp_data !== '0 || data_resp_rdata !== '0 || data_resp_exc_valid !== 1'b0 || data_resp_exc_code !== '0) begin
                    errors++; $display("FAIL reset_mid_outputs got ctrl=%b data=%h want 0", {fetch_req_ready,
                        data_req_ready, mem_req_valid, mem_req_write}, data_resp_rdata);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        checks++;
        if (strobes !== 0) begin errors++; $display("FAIL reset_mid_strobe got %0d want 0", strobes); end
        run_txn(1'b1, 32'h0000_7000, 1'b1, 1'b0, 32'h0000_7100, '0, 0, 1, 32'h55AA_55AA, 1'b0, 4'd0,
                fr, dr, lat, isd, rd, ex, cd, ns, nh, ad, wd, wr, st, zk);
        checks++;
        if ({fr, dr} !== 2'b10 || rd !== 32'h55AA_55AA || lat !== 4) begin
            errors++; $display("FAIL reset_mid_recover got ready=%b data=%h latency=%0d want 10 55aa55aa 4", {fr, dr}, rd, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_arbitration();
        test_misaligned();
        test_timeout();
        test_stall();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
